// File: rtl/pp_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues single-cycle fetches to instruction
// memory and registers each returned word with its address for decode. Handles
// exception/branch redirects, pipeline flush and stall from the hazard unit.
module pp_fetch_stage #(
   parameter int unsigned         INST_ADDR_WIDTH = 32,
   parameter int unsigned         INST_DATA_WIDTH = 32,
   parameter int unsigned         PC_WIDTH        = 32,
   parameter logic [PC_WIDTH-1:0] RESET_ADDRESS   = PC_WIDTH'(32'h0000_0200)
) (
   input  logic                       clk,
   // Active-high despite the name: 1 = reset.
   input  logic                       reset_n,

   input  logic [INST_DATA_WIDTH-1:0] imem_data_in,
   input  logic                       imem_ack,
   output logic [INST_ADDR_WIDTH-1:0] imem_address,
   output logic                       imem_req,

   input  logic                       stall,
   input  logic                       flush,
   input  logic                       branch,
   input  logic                       exception,
   input  logic [31:0]                branch_target,
   input  logic [31:0]                evec,

   output logic [INST_DATA_WIDTH-1:0] inst_data,
   output logic [INST_ADDR_WIDTH-1:0] inst_address,
   output logic                       inst_ready
);

   logic [PC_WIDTH-1:0]        pc_q, pc_d;
   logic [INST_DATA_WIDTH-1:0] inst_data_q, inst_data_d;
   logic [INST_ADDR_WIDTH-1:0] inst_address_q, inst_address_d;
   logic                       inst_ready_q, inst_ready_d;

   logic [PC_WIDTH-1:0]        pc_plus4;
   logic [PC_WIDTH-1:0]        evec_pc;
   logic [PC_WIDTH-1:0]        branch_pc;
   logic                       redirect;
   logic                       fetch_accept;

   // Redirect targets are word aligned and truncated to the PC width.
   always_comb begin
      evec_pc   = PC_WIDTH'(evec & ~32'd3);
      branch_pc = PC_WIDTH'(branch_target & ~32'd3);
      pc_plus4  = pc_q + PC_WIDTH'(4);
   end

   // Memory request: suppressed during reset, stall or a redirect cycle.
   always_comb begin
      redirect     = branch | exception;
      imem_address = pc_q[INST_ADDR_WIDTH-1:0];
      imem_req     = ~reset_n & ~stall & ~redirect;
      // A flush in the same cycle still discards the returned word.
      fetch_accept = imem_req & imem_ack & ~flush;
   end

   // Next-state selection in priority order: exception, branch, flush, stall, fetch.
   always_comb begin
      pc_d           = pc_q;
      inst_data_d    = inst_data_q;
      inst_address_d = inst_address_q;
      inst_ready_d   = inst_ready_q;
      if (exception) begin
         pc_d         = evec_pc;
         inst_ready_d = 1'b0;
      end else if (branch) begin
         pc_d         = branch_pc;
         inst_ready_d = 1'b0;
      end else if (flush) begin
         inst_ready_d = 1'b0;
      end else if (stall) begin
         // Everything holds.
      end else if (fetch_accept) begin
         inst_data_d    = imem_data_in;
         inst_address_d = pc_q[INST_ADDR_WIDTH-1:0];
         inst_ready_d   = 1'b1;
         pc_d           = pc_plus4;
      end else begin
         // Request outstanding but not acked: retry the same PC next cycle.
         inst_ready_d = 1'b0;
      end
   end

   // State registers with synchronous reset; a pending ack is ignored under reset.
   always_ff @(posedge clk) begin
      if (reset_n) begin
         pc_q           <= RESET_ADDRESS;
         inst_data_q    <= '0;
         inst_address_q <= '0;
         inst_ready_q   <= 1'b0;
      end else begin
         pc_q           <= pc_d;
         inst_data_q    <= inst_data_d;
         inst_address_q <= inst_address_d;
         inst_ready_q   <= inst_ready_d;
      end
   end

   // Decode-side outputs come straight from the registers.
   always_comb begin
      inst_data    = inst_data_q;
      inst_address = inst_address_q;
      inst_ready   = inst_ready_q;
   end

endmodule

// File: tb/tb_pp_fetch_stage.sv
// Self-checking bench for pp_fetch_stage: directed steps from the test plan
// followed by a randomized run, both checked against a behavioural model.
module tb_pp_fetch_stage;

   logic        clk;
   logic        reset_n;
   logic [31:0] imem_data_in;
   logic        imem_ack;
   logic [31:0] imem_address;
   logic        imem_req;
   logic        stall;
   logic        flush;
   logic        branch;
   logic        exception;
   logic [31:0] branch_target;
   logic [31:0] evec;
   logic [31:0] inst_data;
   logic [31:0] inst_address;
   logic        inst_ready;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   logic [31:0] m_pc;
   logic [31:0] m_data;
   logic [31:0] m_addr;
   logic        m_ready;

   pp_fetch_stage dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .imem_data_in (imem_data_in),
      .imem_ack     (imem_ack),
      .imem_address (imem_address),
      .imem_req     (imem_req),
      .stall        (stall),
      .flush        (flush),
      .branch       (branch),
      .exception    (exception),
      .branch_target(branch_target),
      .evec         (evec),
      .inst_data    (inst_data),
      .inst_address (inst_address),
      .inst_ready   (inst_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Behavioural rules for one rising edge, applied to the current inputs.
   task automatic model_edge();
      logic req;
      req = !reset_n && !stall && !branch && !exception;
      if (reset_n) begin
         m_pc = 32'h200; m_ready = 0; m_data = 0; m_addr = 0;
      end else if (exception) begin
         m_pc = {evec[31:2], 2'b00}; m_ready = 0;
      end else if (branch) begin
         m_pc = {branch_target[31:2], 2'b00}; m_ready = 0;
      end else if (flush) begin
         m_ready = 0;
      end else if (stall) begin
         // hold
      end else if (req && imem_ack) begin
         m_data = imem_data_in; m_addr = m_pc; m_ready = 1; m_pc = m_pc + 32'd4;
      end else begin
         m_ready = 0;
      end
   endtask

   // One clock: check request outputs before the edge, then registered state after.
   task automatic cycle();
      logic exp_req;
      #1;
      exp_req = !reset_n && !stall && !branch && !exception;
      chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
      chk("imem_address", imem_address, m_pc);
      @(posedge clk);
      model_edge();
      #1;
      chk("inst_ready", {31'd0, inst_ready}, {31'd0, m_ready});
      chk("inst_data", inst_data, m_data);
      chk("inst_address", inst_address, m_addr);
      chk("pc", imem_address, m_pc);
   endtask

   task automatic idle_inputs();
      reset_n = 0; stall = 0; flush = 0; branch = 0; exception = 0;
      imem_ack = 0; imem_data_in = 0; branch_target = 0; evec = 0;
   endtask

   initial begin
      m_pc = 32'h200; m_data = 0; m_addr = 0; m_ready = 0;
      idle_inputs();
      reset_n = 1;
      imem_ack = 1; imem_data_in = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      model_edge();

      // Reset held: no request, PC at reset address, ack ignored.
      cycle();
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_addr", imem_address, 32'h200);
      chk("rst_ready", {31'd0, inst_ready}, 32'd0);

      // Release: request goes out immediately at the reset address.
      idle_inputs();
      #1;
      chk("first_req", {31'd0, imem_req}, 32'd1);
      chk("first_addr", imem_address, 32'h200);

      // Sequential fetch
      imem_ack = 1;
      imem_data_in = 32'h0000_0013; cycle();
      chk("seq0_addr", inst_address, 32'h200);
      chk("seq0_data", inst_data, 32'h0000_0013);
      imem_data_in = 32'h0010_0093; cycle();
      chk("seq1_addr", inst_address, 32'h204);
      imem_data_in = 32'h0020_0113; cycle();
      chk("seq2_addr", inst_address, 32'h208);
      chk("seq2_ready", {31'd0, inst_ready}, 32'd1);

      // Ack gap: PC held, no valid instruction
      imem_ack = 0;
      repeat (2) cycle();
      chk("gap_ready", {31'd0, inst_ready}, 32'd0);
      chk("gap_pc", imem_address, 32'h20C);

      // Stall with ack present: nothing moves
      stall = 1; imem_ack = 1; imem_data_in = 32'h1111_1111;
      repeat (3) cycle();
      chk("stall_pc", imem_address, 32'h20C);
      chk("stall_addr", inst_address, 32'h208);
      // Release: fetch resumes at the held PC this cycle
      stall = 0; imem_data_in = 32'h2222_2222;
      cycle();
      chk("resume_addr", inst_address, 32'h20C);

      // Branch to an unaligned target
      branch = 1; branch_target = 32'h1002;
      cycle();
      chk("br_pc", imem_address, 32'h1000);
      chk("br_ready", {31'd0, inst_ready}, 32'd0);
      branch = 0; imem_data_in = 32'h3333_3333;
      cycle();
      chk("br_inst_addr", inst_address, 32'h1000);

      // Exception beats branch and stall
      exception = 1; evec = 32'h100; branch = 1; branch_target = 32'h4000; stall = 1;
      cycle();
      chk("exc_pc", imem_address, 32'h100);
      exception = 0; branch = 0; stall = 0;

      // Flush alone: bubble, PC unchanged
      cycle();
      flush = 1;
      cycle();
      chk("flush_ready", {31'd0, inst_ready}, 32'd0);
      chk("flush_pc", imem_address, 32'h104);
      flush = 0;

      // Wrap around the top of the address space
      branch = 1; branch_target = 32'hFFFF_FFFC;
      cycle();
      branch = 0; imem_ack = 1;
      cycle();
      chk("wrap0", inst_address, 32'hFFFF_FFFC);
      cycle();
      chk("wrap1", inst_address, 32'h0);

      // Randomized run against the model
      for (int i = 0; i < 400; i++) begin
         reset_n       = ($urandom_range(39) == 0);
         exception     = ($urandom_range(19) == 0);
         branch        = ($urandom_range(9) == 0);
         flush         = ($urandom_range(7) == 0);
         stall         = ($urandom_range(4) == 0);
         imem_ack      = ($urandom_range(3) != 0);
         imem_data_in  = $urandom;
         branch_target = $urandom;
         evec          = $urandom;
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
